cmd_stream_parser: RTL
======================

CMD_STREAM_PARSER -- requirements
Module: cmd_stream_parser

Interface
REQ-001 Parameter DATA_BYTES, default 2, bytes per data word (legal 2 or 4); DW = 8*DATA_BYTES.
REQ-002 Parameter ADDR_W, default 25, memory word-address width.
REQ-003 Parameter NUM_CH, default 2, number of stream output channels (legal 1..8).
REQ-004 mem_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; the block's only reset.
REQ-006 fifo_empty  input  1  byte FIFO empty flag.
REQ-007 fifo_rd  output  1  byte read strobe; fifo_data is valid the cycle after fifo_rd.
REQ-008 fifo_data  input  8  byte from FIFO.
REQ-009 mem_idle  input  1  memory controller idle.
REQ-010 mem_wr_req  output  1  memory write request.
REQ-011 mem_ack  input  1  memory write accepted.
REQ-012 mem_wr_addr  output  ADDR_W  memory write word address.
REQ-013 mem_wr_data  output  DW  memory write data.
REQ-014 st_valid  output  NUM_CH  per-channel stream valid, one-hot or zero.
REQ-015 st_ready  input  NUM_CH  per-channel stream ready.
REQ-016 st_data  output  DW  stream data, shared by all channels.
REQ-017 busy  output  1  high in any state other than HDR.
REQ-018 err_cnt  output  8  count of discarded commands, saturating at 255.

Function
REQ-019 Header is 8 bytes: len[7:0], len[15:8], 0x55, 0xAA, addr[7:0]..addr[31:24] (little-endian).
REQ-020 In HDR, the block shifts each byte into a 4-byte window; header is locked when bytes 3..2 of the window equal 0xAA55; otherwise the shift continues (byte-by-byte resync).
REQ-021 After lock, the next 4 bytes form addr; then state becomes DATA; len==0 returns to HDR with no writes.
REQ-022 addr[31]=0 selects memory target starting at addr[ADDR_W-1:0]; addr[31]=1 selects stream channel addr[30:28].
REQ-023 Channel index >= NUM_CH: err_cnt increments once, len words are read and dropped, no outputs assert.
REQ-024 DATA assembles DATA_BYTES bytes little-endian into one word, then moves to MWR (memory) or SWR (stream).
REQ-025 fifo_rd asserts only when fifo_empty=0 and state is HDR or DATA, never more than one outstanding byte beyond the word currently being assembled; in HDR it also requires mem_idle=1.
REQ-026 MWR: mem_wr_req rises the cycle after the word completes; mem_wr_addr/mem_wr_data stay stable while mem_wr_req=1; mem_wr_req drops the cycle after mem_ack=1.
REQ-027 Memory address increments by 1 per accepted word, wrapping modulo 2^ADDR_W.
REQ-028 SWR: st_valid[ch] holds with stable st_data until st_ready[ch]=1 in the same cycle; transfer completes on that edge.
REQ-029 A word counter (16 bit) counts completed transfers; at count==len-1 on completion, state returns to HDR, else DATA.
REQ-030 mem_ack or st_ready asserted outside a pending request is ignored.
REQ-031 err_cnt holds at 255 on further errors.

Reset
REQ-032 rst=0 asynchronously forces state HDR; fifo_rd, mem_wr_req, st_valid, busy = 0; err_cnt, counters, window, addr, data registers = 0.
REQ-033 Reset mid-command abandons it; after release parsing restarts in HDR with an empty window; no partial write completes.

Configuration
REQ-034 Macro CMD_STREAM_PARSER_FILL_EN defined: signature 0xAA56 also locks a header; one data word then follows, and it is written len times (memory address incrementing, or repeated stream beats) with no further FIFO reads.
REQ-035 Macro undefined: 0xAA56 is not a signature and is shifted through as resync data; no fill logic is built.

Verification
REQ-036 Header len=3, addr=0x00000010, 6 data bytes 01 02 03 04 05 06, DATA_BYTES=2 -> three memory writes: 0x10<-0x0201, 0x11<-0x0403, 0x12<-0x0605, busy falls after the third mem_ack.
REQ-037 Garbage bytes 0x12 0x55 0x34 before valid header len=1, addr=0x80000000 -> single st_valid[0] beat with header's data word; garbage ignored.
REQ-038 Header addr=0xF0000000, NUM_CH=2, len=2 -> 4 bytes consumed, no outputs asserted, err_cnt 0->1.
REQ-039 st_ready[1] held low 10 cycles on channel 1 -> st_valid[1] and st_data stable for all 10 cycles, transfer on first ready cycle.
REQ-040 ADDR_W=25, addr=0x01FFFFFF, len=2 -> writes to 0x1FFFFFF then 0x0000000.
REQ-041 With CMD_STREAM_PARSER_FILL_EN, signature 0xAA56, len=4, addr=0x20, word 0xBEEF -> 0x20..0x23 all 0xBEEF, exactly 10 FIFO reads total; assert rst=0 mid-fill -> mem_wr_req=0 immediately, state HDR.

Source files
------------

// File: rtl/cmd_stream_parser_if.sv
// Handshake and status bundle for cmd_stream_parser: byte FIFO, memory write port,
// per-channel stream outputs and status. master = parser side, slave = environment side.
interface cmd_stream_parser_if #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 25,
  parameter int NUM_CH     = 2
);
  localparam int DW = 8 * DATA_BYTES;

  logic              fifo_empty;
  logic              fifo_rd;
  logic [7:0]        fifo_data;
  logic              mem_idle;
  logic              mem_wr_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic [NUM_CH-1:0] st_valid;
  logic [NUM_CH-1:0] st_ready;
  logic [DW-1:0]     st_data;
  logic              busy;
  logic [7:0]        err_cnt;

  modport master (
    input  fifo_empty, fifo_data, mem_idle, mem_ack, st_ready,
    output fifo_rd, mem_wr_req, mem_wr_addr, mem_wr_data, st_valid, st_data, busy, err_cnt
  );

  modport slave (
    output fifo_empty, fifo_data, mem_idle, mem_ack, st_ready,
    input  fifo_rd, mem_wr_req, mem_wr_addr, mem_wr_data, st_valid, st_data, busy, err_cnt
  );
endinterface

// File: rtl/cmd_stream_parser.sv
// Byte-stream command parser: 8-byte header, then len data words to memory or a stream channel.
// Fill mode (0xAA56 signature, one word repeated len times) is built when CMD_STREAM_PARSER_FILL_EN is defined.
module cmd_stream_parser #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 25,
  parameter int NUM_CH     = 2
) (
  input logic mem_clk,
  input logic rst,
  cmd_stream_parser_if.master bus
);
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [1:0] {HDR, DATA, MWR, SWR} state_t;

  state_t            r_state, w_next;
  logic [23:0]       r_win;
  logic [23:0]       r_addr;
  logic              r_locked;
  logic              r_rdPend;
  logic              r_isStream;
  logic              r_drop;
  logic [1:0]        r_byteIdx;
  logic [15:0]       r_len;
  logic [15:0]       r_wordCnt;
  logic [2:0]        r_ch;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DW-1:0]     r_data;
  logic [7:0]        r_errCnt;

  logic [31:0]       w_win;
  logic [31:0]       w_addrNext;
  logic              w_sigData, w_sigFill, w_fill;
  logic              w_hdrByte, w_addrDone, w_wordDone, w_xferDone, w_lastWord, w_badCh;
  logic [NUM_CH-1:0] w_chSel;
  logic              w_unusedAddrBits;

  // fifo_data is valid exactly one cycle after a read, i.e. whenever r_rdPend is set
  assign w_win            = {bus.fifo_data, r_win};
  assign w_addrNext       = {bus.fifo_data, r_addr};
  assign w_sigData        = (w_win[31:16] == 16'hAA55);
  assign w_hdrByte        = (r_state == HDR) && r_rdPend;
  assign w_addrDone       = w_hdrByte && r_locked && (r_byteIdx == 2'd3);
  assign w_wordDone       = (r_state == DATA) && r_rdPend && (r_byteIdx == 2'(DATA_BYTES - 1));
  assign w_badCh          = w_addrNext[31] && ({29'd0, w_addrNext[30:28]} >= 32'(NUM_CH));
  assign w_lastWord       = (r_wordCnt == r_len - 16'd1);
  assign w_xferDone       = ((r_state == MWR) && bus.mem_ack) ||
                            ((r_state == SWR) && (|(bus.st_ready & w_chSel)));
  assign w_unusedAddrBits = ^w_addrNext;

  always_comb begin
    w_chSel = '0;
    for (int i = 0; i < NUM_CH; i++) w_chSel[i] = (r_ch == 3'(i));
  end

`ifdef CMD_STREAM_PARSER_FILL_EN
  logic r_fill;

  assign w_sigFill = (w_win[31:16] == 16'hAA56);
  assign w_fill    = r_fill;

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst)
      r_fill <= 1'b0;
    else if (w_hdrByte && !r_locked && (w_sigData || w_sigFill))
      r_fill <= w_sigFill;
  end
`else
  assign w_sigFill = 1'b0;
  assign w_fill    = 1'b0;
`endif

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) r_state <= HDR;
    else      r_state <= w_next;
  end

  // Only one byte is ever in flight, so a word boundary never has a stray byte behind it
  always_comb begin
    w_next         = r_state;
    bus.fifo_rd    = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.st_valid   = '0;
    case (r_state)
      HDR: begin
        bus.fifo_rd = rst && !r_rdPend && !bus.fifo_empty && bus.mem_idle;
        if (w_addrDone && (r_len != 16'd0)) w_next = DATA;
      end
      DATA: begin
        bus.fifo_rd = rst && !r_rdPend && !bus.fifo_empty;
        if (w_wordDone) begin
          if (!r_drop)                    w_next = r_isStream ? SWR : MWR;
          else if (w_lastWord || w_fill)  w_next = HDR;
        end
      end
      MWR: begin
        bus.mem_wr_req = 1'b1;
        if (w_xferDone) w_next = w_lastWord ? HDR : (w_fill ? MWR : DATA);
      end
      SWR: begin
        bus.st_valid = w_chSel;
        if (w_xferDone) w_next = w_lastWord ? HDR : (w_fill ? SWR : DATA);
      end
      default: w_next = HDR;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      r_win      <= '0;
      r_addr     <= '0;
      r_locked   <= 1'b0;
      r_rdPend   <= 1'b0;
      r_isStream <= 1'b0;
      r_drop     <= 1'b0;
      r_byteIdx  <= '0;
      r_len      <= '0;
      r_wordCnt  <= '0;
      r_ch       <= '0;
      r_memAddr  <= '0;
      r_data     <= '0;
      r_errCnt   <= '0;
    end else begin
      r_rdPend <= bus.fifo_rd;
      if (w_hdrByte) begin
        if (!r_locked) begin
          if (w_sigData || w_sigFill) begin
            r_locked  <= 1'b1;
            r_len     <= w_win[15:0];
            r_win     <= '0;
            r_byteIdx <= '0;
          end else begin
            r_win <= w_win[31:8];
          end
        end else begin
          r_addr    <= w_addrNext[31:8];
          r_byteIdx <= r_byteIdx + 2'd1;
          if (w_addrDone) begin
            r_locked   <= 1'b0;
            r_wordCnt  <= '0;
            r_memAddr  <= w_addrNext[ADDR_W-1:0];
            r_isStream <= w_addrNext[31];
            r_ch       <= w_addrNext[30:28];
            r_drop     <= w_badCh;
            if (w_badCh && (r_len != 16'd0) && (r_errCnt != 8'hFF))
              r_errCnt <= r_errCnt + 8'd1;
          end
        end
      end
      if ((r_state == DATA) && r_rdPend) begin
        r_data    <= {bus.fifo_data, r_data[DW-1:8]};
        r_byteIdx <= w_wordDone ? 2'd0 : r_byteIdx + 2'd1;
      end
      if ((w_wordDone && r_drop) || w_xferDone)
        r_wordCnt <= w_lastWord ? 16'd0 : r_wordCnt + 16'd1;
      if ((r_state == MWR) && bus.mem_ack)
        r_memAddr <= r_memAddr + 1'b1;
    end
  end

  assign bus.mem_wr_addr = r_memAddr;
  assign bus.mem_wr_data = r_data;
  assign bus.st_data     = r_data;
  assign bus.busy        = (r_state != HDR);
  assign bus.err_cnt     = r_errCnt;
endmodule
